// File: rtl/dma_axi_mem_slave.sv
// AXI4 responder over a MEM_DEPTH x 64-byte SRAM; R data 1 cycle after AR, B 1 cycle after last W, 1 beat/cycle.
// Define AXI_SLV_BACKPRESSURE_EN to gate awready/arready/wready/rvalid with a 16-bit LFSR.
module dma_axi_mem_slave #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         rstn,
  // {aw_id[4],aw_addr[32],aw_len[8],aw_size[3],aw_burst[2],awvalid, w_data[512],w_strb[64],w_last,wvalid,
  //  bready, ar_id[4],ar_addr[32],ar_len[8],ar_size[3],ar_burst[2],arvalid, rready}
  input  logic [679:0] axi_req_i,
  // {awready, wready, b_id[4], b_resp[2], bvalid, arready, r_id[4], r_data[512], r_resp[2], r_last, rvalid}
  output logic [529:0] axi_resp_o
);
  localparam int unsigned IW         = $clog2(MEM_DEPTH);
  localparam logic [31:0] MEM_BYTES  = 32'(MEM_DEPTH * 64);
  localparam logic [1:0]  BURST_INCR = 2'b01;
  localparam logic [1:0]  W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;
  localparam logic        R_IDLE = 1'b0, R_DATA = 1'b1;

  logic [3:0]   aw_id, ar_id;
  logic [31:0]  aw_addr, ar_addr;
  logic [7:0]   aw_len, ar_len;
  logic [2:0]   aw_size, ar_size;
  logic [1:0]   aw_burst, ar_burst;
  logic         aw_valid, w_valid, b_ready, ar_valid, r_ready, w_last;
  logic [511:0] w_data;
  logic [63:0]  w_strb;

  assign {aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid, w_data, w_strb, w_last, w_valid,
          b_ready, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid, r_ready} = axi_req_i;

  // 33-bit offset so addresses below the base wrap to a huge value and fail the range test
  function automatic logic in_win(input logic [31:0] a);
    logic [32:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return off < {1'b0, MEM_BYTES};
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE_ADDR) >> 6;
    return IW'(off);
  endfunction

  logic [511:0] mem_q [MEM_DEPTH];
  logic         bp_w, bp_idle, r_vld;

  logic [1:0]  w_state_q, w_state_d;
  logic [31:0] w_addr_q, w_addr_d;
  logic [7:0]  w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [2:0]  w_size_q, w_size_d;
  logic [1:0]  w_burst_q, w_burst_d;
  logic [3:0]  w_id_q, w_id_d;
  logic        w_err_q, w_err_d;
  logic        aw_rdy, w_rdy, aw_hs, w_hs, w_ok, w_end, b_vld;

  logic         r_state_q, r_state_d;
  logic [31:0]  r_addr_q, r_addr_d, r_nxt, ld_addr;
  logic [7:0]   r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [2:0]   r_size_q, r_size_d;
  logic [1:0]   r_burst_q, r_burst_d, ld_burst, r_resp_q, r_resp_d;
  logic [3:0]   r_id_q, r_id_d;
  logic [511:0] r_data_q, r_data_d;
  logic         ar_rdy, ar_hs, r_hs, r_last, ld;

`ifdef AXI_SLV_BACKPRESSURE_EN
  logic [15:0] lfsr_q;
  logic        r_vld_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lfsr_q  <= LFSR_SEED;
      r_vld_q <= 1'b0;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      if (r_state_q != R_DATA || (r_vld_q && r_ready)) r_vld_q <= 1'b0;
      else if (!r_vld_q && lfsr_q[1])                  r_vld_q <= 1'b1;
    end
  end

  assign bp_w    = lfsr_q[0];
  assign bp_idle = lfsr_q[2];
  assign r_vld   = r_vld_q;
`else
  assign bp_w    = 1'b1;
  assign bp_idle = 1'b1;
  assign r_vld   = (r_state_q == R_DATA);
`endif

  assign aw_rdy = rstn && (w_state_q == W_IDLE) && bp_idle;
  assign w_rdy  = (w_state_q == W_DATA) && bp_w;
  assign aw_hs  = aw_valid && aw_rdy;
  assign w_hs   = w_valid && w_rdy;
  assign w_ok   = in_win(w_addr_q) && (w_burst_q == BURST_INCR);
  assign w_end  = (w_cnt_q == w_len_q);
  assign b_vld  = (w_state_q == W_RESP);

  always_comb begin
    w_state_d = w_state_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    w_id_d    = w_id_q;
    w_cnt_d   = w_cnt_q;
    w_err_d   = w_err_q;
    case (w_state_q)
      W_IDLE: if (aw_hs) begin
        w_addr_d  = aw_addr;
        w_len_d   = aw_len;
        w_size_d  = aw_size;
        w_burst_d = aw_burst;
        w_id_d    = aw_id;
        w_cnt_d   = 8'd0;
        w_err_d   = 1'b0;
        w_state_d = W_DATA;
      end
      W_DATA: if (w_hs) begin
        w_addr_d = w_addr_q + (32'd1 << w_size_q);
        w_cnt_d  = w_cnt_q + 8'd1;
        if (!w_ok || (w_last != w_end)) w_err_d = 1'b1;
        if (w_end) w_state_d = W_RESP;
      end
      W_RESP: if (b_ready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_id_q    <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_id_q    <= w_id_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && w_ok) begin
      for (int i = 0; i < 64; i++) begin
        if (w_strb[i]) mem_q[word_idx(w_addr_q)][i*8 +: 8] <= w_data[i*8 +: 8];
      end
    end
  end

  assign ar_rdy = rstn && (r_state_q == R_IDLE) && bp_idle;
  assign ar_hs  = ar_valid && ar_rdy;
  assign r_hs   = r_vld && r_ready;
  assign r_last = (r_state_q == R_DATA) && (r_cnt_q == r_len_q);
  assign r_nxt  = r_addr_q + (32'd1 << r_size_q);

  // Beat data is registered when the beat is set up, so it reads pre-write contents and holds under stall
  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_id_d    = r_id_q;
    r_cnt_d   = r_cnt_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    ld        = 1'b0;
    ld_addr   = r_nxt;
    ld_burst  = r_burst_q;
    case (r_state_q)
      R_IDLE: if (ar_hs) begin
        r_addr_d  = ar_addr;
        r_len_d   = ar_len;
        r_size_d  = ar_size;
        r_burst_d = ar_burst;
        r_id_d    = ar_id;
        r_cnt_d   = 8'd0;
        r_state_d = R_DATA;
        ld        = 1'b1;
        ld_addr   = ar_addr;
        ld_burst  = ar_burst;
      end
      default: if (r_hs) begin
        if (r_last) begin
          r_state_d = R_IDLE;
        end else begin
          r_addr_d = r_nxt;
          r_cnt_d  = r_cnt_q + 8'd1;
          ld       = 1'b1;
        end
      end
    endcase
    if (ld) begin
      r_data_d = in_win(ld_addr) ? mem_q[word_idx(ld_addr)] : '0;
      r_resp_d = (in_win(ld_addr) && ld_burst == BURST_INCR) ? 2'b00 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_id_q    <= '0;
      r_cnt_q   <= '0;
      r_data_q  <= '0;
      r_resp_q  <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      r_id_q    <= r_id_d;
      r_cnt_q   <= r_cnt_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
    end
  end

  assign axi_resp_o = {aw_rdy, w_rdy,
                       b_vld ? w_id_q : 4'd0, (b_vld && w_err_q) ? 2'b10 : 2'b00, b_vld,
                       ar_rdy,
                       (r_state_q == R_DATA) ? r_id_q : 4'd0, r_data_q, r_resp_q, r_last, r_vld};
endmodule

// File: tb/tb_dma_axi_mem_slave.sv
// Directed bench for dma_axi_mem_slave (default build, no LFSR stalls).
module tb_dma_axi_mem_slave;
  localparam logic [1:0]  INCR  = 2'b01;
  localparam logic [1:0]  FIXED = 2'b00;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]   aw_id = '0, ar_id = '0;
  logic [31:0]  aw_addr = '0, ar_addr = '0;
  logic [7:0]   aw_len = '0, ar_len = '0;
  logic [2:0]   aw_size = '0, ar_size = '0;
  logic [1:0]   aw_burst = '0, ar_burst = '0;
  logic         aw_valid = 1'b0, w_valid = 1'b0, b_ready = 1'b0, ar_valid = 1'b0, r_ready = 1'b0, w_last = 1'b0;
  logic [511:0] w_data = '0;
  logic [63:0]  w_strb = '0;

  logic         aw_ready, w_ready, b_valid, ar_ready, r_last, r_valid;
  logic [3:0]   b_id, r_id;
  logic [1:0]   b_resp, r_resp;
  logic [511:0] r_data;

  logic [679:0] req;
  logic [529:0] resp;

  assign req = {aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid, w_data, w_strb, w_last, w_valid,
                b_ready, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid, r_ready};
  assign {aw_ready, w_ready, b_id, b_resp, b_valid, ar_ready, r_id, r_data, r_resp, r_last, r_valid} = resp;

  dma_axi_mem_slave #(.MEM_DEPTH(256), .BASE_ADDR(32'h0), .LFSR_SEED(16'hACE1)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .axi_req_i  (req),
    .axi_resp_o (resp)
  );

  int total = 0;
  int bad   = 0;

  task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] fill(input logic [7:0] b);
    return {64{b}};
  endfunction

  task automatic do_aw(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                       input logic [1:0] bu, input logic [3:0] id);
    int n = 0;
    aw_addr = a; aw_len = len; aw_size = sz; aw_burst = bu; aw_id = id; aw_valid = 1'b1;
    while (!aw_ready && n < 50) begin @(negedge clk); n++; end
    chkn("aw_handshake", 32'(aw_ready), 32'd1);
    @(negedge clk);
    aw_valid = 1'b0;
  endtask

  task automatic do_ar(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                       input logic [1:0] bu, input logic [3:0] id);
    int n = 0;
    ar_addr = a; ar_len = len; ar_size = sz; ar_burst = bu; ar_id = id; ar_valid = 1'b1;
    while (!ar_ready && n < 50) begin @(negedge clk); n++; end
    chkn("ar_handshake", 32'(ar_ready), 32'd1);
    @(negedge clk);
    ar_valid = 1'b0;
  endtask

  task automatic do_w(input logic [511:0] d, input logic [63:0] s, input logic l);
    int n = 0;
    w_data = d; w_strb = s; w_last = l; w_valid = 1'b1;
    while (!w_ready && n < 50) begin @(negedge clk); n++; end
    chkn("w_handshake", 32'(w_ready), 32'd1);
    @(negedge clk);
    w_valid = 1'b0;
  endtask

  task automatic wait_b(input logic [1:0] exp_resp, input logic [3:0] exp_id);
    int n = 0;
    b_ready = 1'b1;
    while (!b_valid && n < 50) begin @(negedge clk); n++; end
    chkn("b_valid", 32'(b_valid), 32'd1);
    chkn("b_resp", 32'(b_resp), 32'(exp_resp));
    chkn("b_id", 32'(b_id), 32'(exp_id));
    @(negedge clk);
    b_ready = 1'b0;
  endtask

  task automatic rd_beat(output logic [511:0] d, output logic [1:0] rs, output logic l);
    int n = 0;
    r_ready = 1'b1;
    while (!r_valid && n < 50) begin @(negedge clk); n++; end
    chkn("r_valid", 32'(r_valid), 32'd1);
    d = r_data; rs = r_resp; l = r_last;
    @(negedge clk);
    r_ready = 1'b0;
  endtask

  initial begin
    logic [511:0] d, exp_w0, exp_w1, hold_d;
    logic [1:0]   rs;
    logic         l, hold_l, prev_stall;
    int           beats, cyc;

    // Reset state
    repeat (3) @(negedge clk);
    chkn("rst_awready", 32'(aw_ready), 32'd0);
    chkn("rst_arready", 32'(ar_ready), 32'd0);
    chkn("rst_wready", 32'(w_ready), 32'd0);
    chkn("rst_bvalid", 32'(b_valid), 32'd0);
    chkn("rst_rvalid", 32'(r_valid), 32'd0);
    chkn("rst_rlast", 32'(r_last), 32'd0);
    chkn("rst_bresp_rresp", 32'({b_resp, r_resp}), 32'd0);
    chkd("rst_rdata", r_data, 512'd0);
    rstn = 1'b1;
    @(negedge clk);
    chkn("idle_awready", 32'(aw_ready), 32'd1);
    chkn("idle_arready", 32'(ar_ready), 32'd1);

    // Word 0 = 0x11 pattern, then the single full-word write of 0xA5 at 0x40
    do_aw(32'h0, 8'd0, 3'd6, INCR, 4'd0);
    do_w(fill(8'h11), ONES, 1'b1);
    wait_b(2'b00, 4'd0);
    do_aw(32'h40, 8'd0, 3'd6, INCR, 4'd3);
    chkn("wready_latency", 32'(w_ready), 32'd1);
    do_w(fill(8'hA5), ONES, 1'b1);
    chkn("b_after_last_w", 32'(b_valid), 32'd1);
    wait_b(2'b00, 4'd3);
    do_ar(32'h40, 8'd0, 3'd6, INCR, 4'd5);
    chkn("rvalid_latency", 32'(r_valid), 32'd1);
    chkn("single_rid", 32'(r_id), 32'd5);
    rd_beat(d, rs, l);
    chkd("single_rdata", d, fill(8'hA5));
    chkn("single_rresp", 32'(rs), 32'd0);
    chkn("single_rlast", 32'(l), 32'd1);

    // Narrow 4-byte INCR beats crossing from word 0 into word 1
    do_aw(32'h3C, 8'd3, 3'd2, INCR, 4'd1);
    do_w(fill(8'hB0), 64'hF << 60, 1'b0);
    do_w(fill(8'hB1), 64'hF << 0,  1'b0);
    do_w(fill(8'hB2), 64'hF << 4,  1'b0);
    do_w(fill(8'hB3), 64'hF << 8,  1'b1);
    wait_b(2'b00, 4'd1);
    exp_w0 = fill(8'h11);
    exp_w1 = fill(8'hA5);
    for (int i = 60; i < 64; i++) exp_w0[i*8 +: 8] = 8'hB0;
    for (int i = 0; i < 4; i++) begin
      exp_w1[i*8 +: 8]      = 8'hB1;
      exp_w1[(i+4)*8 +: 8]  = 8'hB2;
      exp_w1[(i+8)*8 +: 8]  = 8'hB3;
    end
    do_ar(32'h0, 8'd1, 3'd6, INCR, 4'd2);
    rd_beat(d, rs, l);
    chkd("narrow_word0", d, exp_w0);
    chkn("narrow_rlast0", 32'(l), 32'd0);
    rd_beat(d, rs, l);
    chkd("narrow_word1", d, exp_w1);
    chkn("narrow_rlast1", 32'(l), 32'd1);

    // Non-INCR read returns the word but flags SLVERR
    do_ar(32'h40, 8'd0, 3'd6, FIXED, 4'd2);
    rd_beat(d, rs, l);
    chkn("fixed_rresp", 32'(rs), 32'd2);
    chkd("fixed_rdata", d, exp_w1);

    // Out-of-range write/read at BASE + MEM_DEPTH*64
    do_aw(32'h4000, 8'd1, 3'd6, INCR, 4'd6);
    do_w(fill(8'hEE), ONES, 1'b0);
    do_w(fill(8'hEE), ONES, 1'b1);
    wait_b(2'b10, 4'd6);
    do_ar(32'h4000, 8'd1, 3'd6, INCR, 4'd7);
    rd_beat(d, rs, l);
    chkd("oor_rdata0", d, 512'd0);
    chkn("oor_rresp0", 32'(rs), 32'd2);
    rd_beat(d, rs, l);
    chkd("oor_rdata1", d, 512'd0);
    chkn("oor_rresp1", 32'(rs), 32'd2);
    chkn("oor_rlast1", 32'(l), 32'd1);
    do_ar(32'h0, 8'd0, 3'd6, INCR, 4'd0);
    rd_beat(d, rs, l);
    chkd("oor_mem_intact", d, exp_w0);

    // Words 32..47 = 0x40+k
    do_aw(32'h800, 8'd15, 3'd6, INCR, 4'd4);
    for (int k = 0; k < 16; k++) do_w(fill(8'(8'h40 + k)), ONES, k == 15);
    wait_b(2'b00, 4'd4);

    // Concurrent 16-beat write (words 0..15) and 16-beat read (words 32..47), no stalls
    aw_addr = 32'h0; aw_len = 8'd15; aw_size = 3'd6; aw_burst = INCR; aw_id = 4'd8; aw_valid = 1'b1;
    ar_addr = 32'h800; ar_len = 8'd15; ar_size = 3'd6; ar_burst = INCR; ar_id = 4'd9; ar_valid = 1'b1;
    chkn("conc_ready", 32'({aw_ready, ar_ready}), 32'd3);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      aw_valid = 1'b0; ar_valid = 1'b0;
      w_valid = 1'b1; w_data = fill(8'(8'h80 + c)); w_strb = ONES; w_last = (c == 15);
      r_ready = 1'b1;
      chkn("conc_wready_rvalid", 32'({w_ready, r_valid}), 32'd3);
      chkd("conc_rdata", r_data, fill(8'(8'h40 + c)));
      chkn("conc_rlast", 32'(r_last), 32'(c == 15));
    end
    @(negedge clk);
    w_valid = 1'b0; r_ready = 1'b0; w_last = 1'b0;
    chkn("conc_bvalid", 32'(b_valid), 32'd1);
    chkn("conc_bresp", 32'(b_resp), 32'd0);
    chkn("conc_r_done", 32'(r_valid), 32'd0);
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
    chkn("conc_b_done", 32'(b_valid), 32'd0);

    // Read back-pressure: rready 1,0,0,1,0,0,... over 8 beats of words 0..7
    do_ar(32'h0, 8'd7, 3'd6, INCR, 4'd10);
    beats = 0; cyc = 0; prev_stall = 1'b0; hold_d = '0; hold_l = 1'b0;
    while (beats < 8 && cyc < 100) begin
      r_ready = (cyc % 3 == 0);
      if (prev_stall) begin
        chkd("bp_hold_rdata", r_data, hold_d);
        chkn("bp_hold_rlast", 32'(r_last), 32'(hold_l));
      end
      prev_stall = 1'b0;
      if (r_valid) begin
        if (r_ready) begin
          chkd("bp_rdata", r_data, fill(8'(8'h80 + beats)));
          chkn("bp_rlast", 32'(r_last), 32'(beats == 7));
          beats++;
        end else begin
          prev_stall = 1'b1; hold_d = r_data; hold_l = r_last;
        end
      end
      @(negedge clk);
      cyc++;
    end
    r_ready = 1'b0;
    chkn("bp_beats", 32'(beats), 32'd8);
    chkn("bp_done", 32'(r_valid), 32'd0);

    // Reset during beat 3 of an 8-beat read of words 32..39
    do_ar(32'h800, 8'd7, 3'd6, INCR, 4'd11);
    rd_beat(d, rs, l);
    chkd("mid_beat0", d, fill(8'h40));
    rd_beat(d, rs, l);
    rd_beat(d, rs, l);
    chkn("mid_beat3_valid", 32'(r_valid), 32'd1);
    rstn = 1'b0;
    #1;
    chkn("mid_rst_rvalid", 32'(r_valid), 32'd0);
    chkn("mid_rst_arready", 32'(ar_ready), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chkn("mid_rel_arready", 32'(ar_ready), 32'd1);
    do_ar(32'h8C0, 8'd0, 3'd6, INCR, 4'd12);
    rd_beat(d, rs, l);
    chkd("mid_mem_intact", d, fill(8'h43));
    chkn("mid_fresh_rlast", 32'(l), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
